irq_pending_ctrl: RTL and testbench

//  Request-capture and dispatch stage wrapped around the 8-input priority encoder.
//  - Captures rising edges on 8 synchronous request lines into sticky pending bits.
//  - Drives the masked pending vector into the encoder and takes back its index/valid.
//  - Offers the highest-priority index downstream on a valid/ready handshake.
//  - Clears the serviced bit and holds off the next dispatch until service completes.

---
 rtl/irq_pkg.sv | 19 +
 rtl/req_pending_bank.sv | 59 +++++
 rtl/irq_pending_ctrl.sv | 101 ++++++++++
 tb/tb_irq_pending_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
//   Shared constants and types for the interrupt request capture/dispatch stage.
//   N_REQ : number of request lines (matches the external priority encoder)
//   IDX_W : width of an encoded line index
//   state_t : dispatch FSM states
// -----------------------------------------------------------------------------
package irq_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/req_pending_bank.sv
// -----------------------------------------------------------------------------
// req_pending_bank
//   Rising-edge capture of the request lines into sticky pending bits, masking
//   of the pending vector towards the encoder, and overflow detection.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     req_in     : level request lines; a rising edge raises a new request
//     mask       : 1 = line may be presented to the encoder
//     clr        : one-hot clear of the bit just accepted downstream
//     ovf_clr    : clears the sticky overflow flag
//     enc_in     : pending & mask, combinational
//     overflow   : sticky, an edge arrived on a line that was still pending
// -----------------------------------------------------------------------------
module req_pending_bank
    import irq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_in,
    input  logic [N_REQ-1:0] mask,
    input  logic [N_REQ-1:0] clr,
    input  logic             ovf_clr,
    output logic [N_REQ-1:0] enc_in,
    output logic             overflow
);

    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] pending_q;
    logic [N_REQ-1:0] pending_d;
    logic [N_REQ-1:0] rise;
    logic             overflow_q;
    logic             overflow_d;

    always_comb begin
        rise      = req_in & ~req_q;
        // A new edge on the bit being cleared re-arms it: set wins over clear.
        pending_d = rise | (pending_q & ~clr);
        // A re-arrival in the accept cycle is a fresh request, not an overflow.
        overflow_d = (|(rise & pending_q & ~clr)) | (overflow_q & ~ovf_clr);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            req_q      <= req_in;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign enc_in   = pending_q & mask;
    assign overflow = overflow_q;

endmodule

// File: rtl/irq_pending_ctrl.sv
// -----------------------------------------------------------------------------
// irq_pending_ctrl
//   Request capture and dispatch around an external 8-input priority encoder.
//   Pending requests are masked and sent to the encoder; the winning index is
//   offered downstream on a valid/ready handshake and further dispatch is held
//   off until the consumer signals service completion.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     req_in, mask        : request lines and per-line enables
//     enc_in              : masked pending vector to the encoder
//     enc_idx, enc_valid  : encoder result (7 = highest priority)
//     irq_valid, irq_idx  : dispatch offer; index frozen while offered
//     irq_ready           : consumer accepts the offer
//     svc_done            : one-cycle pulse ending service
//     busy                : high while the accepted request is in service
//     overflow, ovf_clr   : sticky re-request-while-pending flag and its clear
// -----------------------------------------------------------------------------
module irq_pending_ctrl
    import irq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_in,
    input  logic [N_REQ-1:0] mask,
    output logic [N_REQ-1:0] enc_in,
    input  logic [IDX_W-1:0] enc_idx,
    input  logic             enc_valid,
    output logic             irq_valid,
    output logic [IDX_W-1:0] irq_idx,
    input  logic             irq_ready,
    input  logic             svc_done,
    output logic             busy,
    output logic             overflow,
    input  logic             ovf_clr
);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] irq_idx_q;
    logic [IDX_W-1:0] irq_idx_d;
    logic             accept;
    logic [N_REQ-1:0] clr;

    // irq_ready only counts while an offer is actually on the bus.
    assign accept = (state_q == OFFER) && irq_ready;
    assign clr    = accept ? (N_REQ'(1) << irq_idx_q) : '0;

    req_pending_bank u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_in   (req_in),
        .mask     (mask),
        .clr      (clr),
        .ovf_clr  (ovf_clr),
        .enc_in   (enc_in),
        .overflow (overflow)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        irq_idx_d = irq_idx_q;
        unique case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    irq_idx_d = enc_idx;
                    state_d   = OFFER;
                end
            end
            // The offered index is frozen: later mask or pending changes
            // neither retract nor re-rank it.
            OFFER: begin
                if (irq_ready) begin
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (svc_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            irq_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            irq_idx_q <= irq_idx_d;
        end
    end

    assign irq_valid = (state_q == OFFER);
    assign busy      = (state_q == SERVICE);
    assign irq_idx   = irq_idx_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_pending_ctrl
//   Directed scenarios followed by randomized traffic. A behavioural model
//   predicts the pending set, overflow and dispatch offers; expected offers and
//   per-cycle status go into queues that a separate negedge monitor drains.
// -----------------------------------------------------------------------------
module tb_irq_pending_ctrl;
    import irq_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_REQ-1:0] req_in = '0;
    logic [N_REQ-1:0] mask = 8'hFF;
    logic [N_REQ-1:0] enc_in;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_valid;
    logic             irq_valid;
    logic [IDX_W-1:0] irq_idx;
    logic             irq_ready = 1'b0;
    logic             svc_done = 1'b0;
    logic             busy;
    logic             overflow;
    logic             ovf_clr = 1'b0;

    always #5 clk = ~clk;

    // Environment: the priority encoder that the parent would instantiate.
    always_comb begin
        enc_valid = |enc_in;
        enc_idx   = '0;
        for (int i = 0; i < N_REQ; i++)
            if (enc_in[i]) enc_idx = IDX_W'(i);
    end

    irq_pending_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .mask      (mask),
        .enc_in    (enc_in),
        .enc_idx   (enc_idx),
        .enc_valid (enc_valid),
        .irq_valid (irq_valid),
        .irq_idx   (irq_idx),
        .irq_ready (irq_ready),
        .svc_done  (svc_done),
        .busy      (busy),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct { int cyc; int idx; } offer_t;
    typedef struct { bit valid; bit busy; bit ovf; logic [7:0] pend; } stat_t;

    offer_t     offer_q[$];
    stat_t      stat_q[$];
    logic [7:0] m_pend = '0;
    logic [7:0] m_prev = '0;
    bit         m_offer = 0;
    bit         m_svc = 0;
    bit         m_ovf = 0;
    int         m_idx = 0;
    bit         mon_en = 0;

    function automatic int highest(input logic [7:0] v);
        for (int i = 7; i >= 0; i--)
            if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_prev = '0; m_offer = 0; m_svc = 0; m_ovf = 0; m_idx = 0;
        offer_q.delete();
        stat_q.delete();
    endtask

    // What happens at one clock edge given the inputs applied before it.
    task automatic model_edge(input logic [7:0] req, input logic [7:0] msk,
                              input bit rdy, input bit done, input bit oclr);
        logic [7:0] clr;
        logic [7:0] rise;
        int         top;
        bit         acc;
        acc  = m_offer && rdy;
        clr  = '0;
        if (acc) clr[m_idx] = 1'b1;
        rise = req & ~m_prev;
        top  = highest(m_pend & msk);
        if (|(rise & m_pend & ~clr)) m_ovf = 1;
        else if (oclr)               m_ovf = 0;
        m_pend = rise | (m_pend & ~clr);
        m_prev = req;
        if (!m_offer && !m_svc) begin
            if (top >= 0) begin
                m_offer = 1;
                m_idx   = top;
                offer_q.push_back('{cyc, top});
            end
        end else if (m_offer) begin
            if (rdy) begin m_offer = 0; m_svc = 1; end
        end else if (done) begin
            m_svc = 0;
        end
    endtask

    task automatic step(input logic [7:0] req, input logic [7:0] msk,
                        input bit rdy, input bit done, input bit oclr);
        req_in = req; mask = msk; irq_ready = rdy; svc_done = done; ovf_clr = oclr;
        @(posedge clk);
        #1;
        model_edge(req, msk, rdy, done, oclr);
        stat_q.push_back('{m_offer, m_svc, m_ovf, m_pend});
    endtask

    // ---------------- monitor ----------------
    initial begin
        bit               prev_valid = 0;
        logic [IDX_W-1:0] held_idx = '0;
        stat_t            s;
        offer_t           o;
        forever begin
            @(negedge clk);
            if (mon_en && stat_q.size() > 0) begin
                s = stat_q.pop_front();
                check("irq_valid", 32'(irq_valid), 32'(s.valid));
                check("busy",      32'(busy),      32'(s.busy));
                check("overflow",  32'(overflow),  32'(s.ovf));
                check("enc_in",    32'(enc_in),    32'(s.pend & mask));
                if (irq_valid && !prev_valid) begin
                    check("offer_expected", 32'(offer_q.size() != 0), 32'd1);
                    if (offer_q.size() != 0) begin
                        o = offer_q.pop_front();
                        check("offer_idx", 32'(irq_idx), 32'(o.idx));
                        check("offer_cyc", 32'(cyc), 32'(o.cyc));
                    end
                    held_idx = irq_idx;
                end else if (irq_valid) begin
                    check("irq_idx_stable", 32'(irq_idx), 32'(held_idx));
                end
            end
            prev_valid = irq_valid;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rq;
        logic [7:0] mk;

        // Reset values, with mask open so enc_in=0 is meaningful.
        repeat (2) @(posedge clk);
        #1;
        check("rst_irq_valid", 32'(irq_valid), 32'd0);
        check("rst_irq_idx",   32'(irq_idx),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_enc_in",    32'(enc_in),    32'd0);
        rst_n = 1'b1;
        model_reset();
        mon_en = 1;

        // 1: single request on line 2, accept, service.
        step(8'h04, 8'hFF, 0, 0, 0);
        step(8'h04, 8'hFF, 0, 0, 0);
        step(8'h00, 8'hFF, 1, 0, 0);
        step(8'h00, 8'hFF, 0, 1, 0);
        step(8'h00, 8'hFF, 0, 0, 0);

        // 2: simultaneous edges on 7 and 0; 7 first, 0 two cycles after done.
        step(8'h81, 8'hFF, 0, 0, 0);
        step(8'h00, 8'hFF, 0, 0, 0);
        step(8'h00, 8'hFF, 1, 0, 0);
        step(8'h00, 8'hFF, 0, 1, 0);
        step(8'h00, 8'hFF, 0, 0, 0);
        step(8'h00, 8'hFF, 1, 0, 0);
        step(8'h00, 8'hFF, 0, 1, 0);
        step(8'h00, 8'hFF, 0, 0, 0);

        // 3: masked line stays pending without an offer until unmasked.
        repeat (4) step(8'h01, 8'hFE, 0, 0, 0);
        step(8'h00, 8'hFF, 0, 0, 0);
        step(8'h00, 8'hFF, 1, 0, 0);
        step(8'h00, 8'hFF, 0, 1, 0);
        step(8'h00, 8'hFF, 0, 0, 0);

        // 4: line 3 re-arrives in its accept cycle: stays pending, no overflow.
        step(8'h08, 8'hFF, 0, 0, 0);
        step(8'h00, 8'hFF, 0, 0, 0);
        step(8'h08, 8'hFF, 1, 0, 0);
        step(8'h00, 8'hFF, 0, 1, 0);
        step(8'h00, 8'hFF, 0, 0, 0);
        step(8'h00, 8'hFF, 1, 0, 0);
        step(8'h00, 8'hFF, 0, 1, 0);
        step(8'h00, 8'hFF, 0, 0, 0);

        // 5: edge on still-pending line 5 sets overflow; ovf_clr drops it.
        step(8'h20, 8'hFF, 0, 0, 0);
        step(8'h00, 8'hFF, 0, 0, 0);
        step(8'h20, 8'hFF, 0, 0, 0);
        step(8'h00, 8'hFF, 0, 0, 0);
        step(8'h00, 8'hFF, 1, 0, 1);
        step(8'h00, 8'hFF, 0, 1, 0);
        step(8'h00, 8'hFF, 0, 0, 0);

        // Randomized traffic: sparse line toggles, occasional partial masks.
        rq = '0;
        for (int n = 0; n < 1500; n++) begin
            rq = rq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            mk = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'hFF;
            step(rq, mk, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0);
        end

        // Drain everything still pending.
        repeat (40) step(8'h00, 8'hFF, 1, 1, 0);

        // 6: reset while in service with lines 4 and 5 pending.
        step(8'h01, 8'hFF, 0, 0, 0);
        step(8'h00, 8'hFF, 0, 0, 0);
        step(8'h00, 8'hFF, 1, 0, 0);
        step(8'h30, 8'hFF, 0, 0, 0);
        step(8'h00, 8'hFF, 0, 0, 0);
        mon_en = 0;
        rst_n  = 1'b0;
        req_in = '0; irq_ready = 0; svc_done = 0; ovf_clr = 0;
        #1;
        check("mid_rst_irq_valid", 32'(irq_valid), 32'd0);
        check("mid_rst_busy",      32'(busy),      32'd0);
        check("mid_rst_enc_in",    32'(enc_in),    32'd0);
        check("mid_rst_irq_idx",   32'(irq_idx),   32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1;
        repeat (4) step(8'h00, 8'hFF, 0, 0, 0);
        step(8'h10, 8'hFF, 0, 0, 0);
        step(8'h00, 8'hFF, 0, 0, 0);
        step(8'h00, 8'hFF, 1, 0, 0);
        step(8'h00, 8'hFF, 0, 1, 0);
        repeat (3) step(8'h00, 8'hFF, 0, 0, 0);

        @(negedge clk);
        #1;
        check("offers_outstanding", 32'(offer_q.size()), 32'd0);
        check("status_outstanding", 32'(stat_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
